// File: rtl/sw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sw_pkg
// Brief    : Shared base/state types and helpers for the stream scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package sw_pkg;

  typedef enum logic [1:0] {
    BASE_A = 2'b00,
    BASE_G = 2'b01,
    BASE_T = 2'b10,
    BASE_C = 2'b11
  } base_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_QLOAD  = 3'd1,
    ST_READY  = 3'd2,
    ST_STREAM = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  localparam int QLEN_WIDTH = 7;
  localparam int PERF_WIDTH = 32;

  // Bias the array adds to its signed result: 2**(width-1).
  function automatic logic [31:0] zero_bias(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

  function automatic base_t ConvertToBase(input logic [7:0] ch);
    case (ch)
      8'h41, 8'h61: return BASE_A;
      8'h47, 8'h67: return BASE_G;
      8'h54, 8'h74: return BASE_T;
      8'h43, 8'h63: return BASE_C;
      default:      return BASE_A;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sw_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sw_tag_fifo
// Brief    : DEPTH x WIDTH synchronous tag FIFO; push and pop may coincide,
//            including a push into a full FIFO that is popped in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sw_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full     = (cnt_q == (PW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sw_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sw_stream_scheduler
// Brief    : Loads the query, streams tagged database sequences into the
//            scoring array and pairs array results with their sequence IDs.
//            Optional SW_SCHED_PERF_EN adds perf_bases/perf_seqs counters.
// Revision : 1.0 - initial release
// ============================================================================
module sw_stream_scheduler
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = 12,
  parameter int LENGTH      = 48,
  parameter int MAX_OUT     = 4,
  parameter int ID_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   q_valid,
  input  logic [1:0]             q_base,
  input  logic                   q_last,
  output logic                   q_ready,
  input  logic                   db_valid,
  input  logic [1:0]             db_base,
  input  logic                   db_last,
  output logic                   db_ready,
  output logic                   sa_en,
  output logic [1:0]             sa_data,
  output logic [2*LENGTH-1:0]    sa_query,
  output logic [QLEN_WIDTH-1:0]  sa_qlen,
  input  logic                   sa_vld,
  input  logic [SCORE_WIDTH-1:0] sa_result,
  output logic                   res_valid,
  output logic [ID_WIDTH-1:0]    res_id,
  output logic [SCORE_WIDTH-1:0] res_score,
  output logic                   q_ovf,
  output logic                   err_orphan
`ifdef SW_SCHED_PERF_EN
  ,
  output logic [PERF_WIDTH-1:0]  perf_bases,
  output logic [PERF_WIDTH-1:0]  perf_seqs
`endif
);

  localparam logic [SCORE_WIDTH-1:0] ZERO  = SCORE_WIDTH'(zero_bias(SCORE_WIDTH));
  localparam logic [QLEN_WIDTH-1:0]  LEN_C = QLEN_WIDTH'(LENGTH);

  state_t                   state_q, state_d;
  logic [QLEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [2*LENGTH-1:0]      query_q, query_d;
  logic [QLEN_WIDTH-1:0]    qlen_q, qlen_d;
  logic                     q_ready_q, q_ready_d;
  logic                     q_ovf_q, q_ovf_d;
  logic [ID_WIDTH-1:0]      id_q, id_d;
  logic                     sa_en_q, sa_en_d;
  base_t                    sa_data_q, sa_data_d;
  logic                     vld_prev_q, vld_prev_d;
  logic                     res_valid_q, res_valid_d;
  logic [ID_WIDTH-1:0]      res_id_q, res_id_d;
  logic [SCORE_WIDTH-1:0]   res_score_q, res_score_d;
  logic                     err_orphan_q, err_orphan_d;

  logic                     q_acc, db_acc, push, vld_rise;
  logic                     tag_full, tag_empty;
  logic [ID_WIDTH-1:0]      tag_head;

  // db_ready stays combinational so a pop can never unblock READY in the same
  // cycle: the full flag it sees is the pre-pop one.
  assign db_ready = ((state_q == ST_READY) && !tag_full) || (state_q == ST_STREAM);
  assign q_acc    = q_valid & q_ready_q;
  assign db_acc   = db_valid & db_ready;
  assign push     = db_acc & (state_q == ST_READY);
  assign vld_rise = sa_vld & ~vld_prev_q;

  sw_tag_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (ID_WIDTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (id_q),
    .pop       (vld_rise),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    query_d      = query_q;
    qlen_d       = qlen_q;
    q_ovf_d      = q_ovf_q;
    id_d         = id_q;
    sa_data_d    = sa_data_q;
    res_id_d     = res_id_q;
    res_score_d  = res_score_q;
    err_orphan_d = err_orphan_q;

    case (state_q)
      ST_IDLE, ST_QLOAD: begin
        if (q_acc) begin
          if (cnt_q < LEN_C) begin
            for (int k = 0; k < LENGTH; k++) begin
              if (cnt_q == QLEN_WIDTH'(k)) query_d[2*k +: 2] = q_base;
            end
            cnt_d = cnt_q + 1'b1;
          end else begin
            q_ovf_d = 1'b1;
          end
          if (q_last) begin
            qlen_d  = (cnt_q < LEN_C) ? cnt_q : LEN_C - 1'b1;
            cnt_d   = '0;
            state_d = ST_READY;
          end else begin
            state_d = ST_QLOAD;
          end
        end
      end
      ST_READY: begin
        if (db_acc) begin
          state_d = db_last ? ST_GAP : ST_STREAM;
        end else if (q_valid && tag_empty) begin
          // Reload only once every in-flight sequence has reported back.
          state_d = ST_IDLE;
          query_d = '0;
        end
      end
      ST_STREAM: begin
        if (db_acc && db_last) state_d = ST_GAP;
      end
      ST_GAP:  state_d = ST_READY;
      default: state_d = ST_IDLE;
    endcase

    if (push) id_d = id_q + 1'b1;

    q_ready_d  = (state_d == ST_IDLE) || (state_d == ST_QLOAD);
    sa_en_d    = db_acc;
    if (db_acc) sa_data_d = base_t'(db_base);
    vld_prev_d  = sa_vld;
    res_valid_d = vld_rise;
    if (vld_rise) begin
      res_id_d    = tag_empty ? '0 : tag_head;
      res_score_d = sa_result + ZERO;
      if (tag_empty) err_orphan_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      query_q      <= '0;
      qlen_q       <= '0;
      q_ready_q    <= 1'b0;
      q_ovf_q      <= 1'b0;
      id_q         <= '0;
      sa_en_q      <= 1'b0;
      sa_data_q    <= BASE_A;
      vld_prev_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      res_id_q     <= '0;
      res_score_q  <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      query_q      <= query_d;
      qlen_q       <= qlen_d;
      q_ready_q    <= q_ready_d;
      q_ovf_q      <= q_ovf_d;
      id_q         <= id_d;
      sa_en_q      <= sa_en_d;
      sa_data_q    <= sa_data_d;
      vld_prev_q   <= vld_prev_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_score_q  <= res_score_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign q_ready    = q_ready_q;
  assign sa_en      = sa_en_q;
  assign sa_data    = sa_data_q;
  assign sa_query   = query_q;
  assign sa_qlen    = qlen_q;
  assign res_valid  = res_valid_q;
  assign res_id     = res_id_q;
  assign res_score  = res_score_q;
  assign q_ovf      = q_ovf_q;
  assign err_orphan = err_orphan_q;

`ifdef SW_SCHED_PERF_EN
  logic [PERF_WIDTH-1:0] perf_bases_q, perf_bases_d;
  logic [PERF_WIDTH-1:0] perf_seqs_q, perf_seqs_d;

  always_comb begin
    perf_bases_d = perf_bases_q;
    perf_seqs_d  = perf_seqs_q;
    if (db_acc && (perf_bases_q != '1)) perf_bases_d = perf_bases_q + 1'b1;
    if (res_valid_q && (perf_seqs_q != '1)) perf_seqs_d = perf_seqs_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_bases_q <= '0;
      perf_seqs_q  <= '0;
    end else begin
      perf_bases_q <= perf_bases_d;
      perf_seqs_q  <= perf_seqs_d;
    end
  end

  assign perf_bases = perf_bases_q;
  assign perf_seqs  = perf_seqs_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sw_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_stream_scheduler
// Brief    : Self-checking bench for sw_stream_scheduler (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sw_stream_scheduler;
  import sw_pkg::*;

  localparam int SW  = 12;
  localparam int LEN = 48;
  localparam int MO  = 4;
  localparam int IW  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              q_valid = 1'b0, q_last = 1'b0, q_ready;
  logic [1:0]        q_base = 2'd0;
  logic              db_valid = 1'b0, db_last = 1'b0, db_ready;
  logic [1:0]        db_base = 2'd0;
  logic              sa_en;
  logic [1:0]        sa_data;
  logic [2*LEN-1:0]  sa_query;
  logic [6:0]        sa_qlen;
  logic              sa_vld = 1'b0;
  logic [SW-1:0]     sa_result = '0;
  logic              res_valid;
  logic [IW-1:0]     res_id;
  logic [SW-1:0]     res_score;
  logic              q_ovf, err_orphan;
`ifdef SW_SCHED_PERF_EN
  logic [31:0]       perf_bases, perf_seqs;
`endif

  sw_stream_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .q_valid    (q_valid),
    .q_base     (q_base),
    .q_last     (q_last),
    .q_ready    (q_ready),
    .db_valid   (db_valid),
    .db_base    (db_base),
    .db_last    (db_last),
    .db_ready   (db_ready),
    .sa_en      (sa_en),
    .sa_data    (sa_data),
    .sa_query   (sa_query),
    .sa_qlen    (sa_qlen),
    .sa_vld     (sa_vld),
    .sa_result  (sa_result),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_score  (res_score),
    .q_ovf      (q_ovf),
    .err_orphan (err_orphan)
`ifdef SW_SCHED_PERF_EN
    ,
    .perf_bases (perf_bases),
    .perf_seqs  (perf_seqs)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] result;
    logic [SW-1:0] score;
  } vec_t;

  vec_t tbl[6];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   tags[$];
  int   nxt_id = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_q_ready"}, q_ready, 0);
    chk({t, "_db_ready"}, db_ready, 0);
    chk({t, "_sa_en"}, sa_en, 0);
    chk({t, "_sa_data"}, sa_data, 0);
    chk({t, "_sa_query"}, sa_query, 0);
    chk({t, "_sa_qlen"}, sa_qlen, 0);
    chk({t, "_res_valid"}, res_valid, 0);
    chk({t, "_res_id"}, res_id, 0);
    chk({t, "_res_score"}, res_score, 0);
    chk({t, "_q_ovf"}, q_ovf, 0);
    chk({t, "_err_orphan"}, err_orphan, 0);
  endtask

  task automatic wait_q_ready();
    int n = 0;
    while (q_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk("q_ready_timeout", q_ready, 1);
  endtask

  task automatic wait_db_ready();
    int n = 0;
    while (db_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk("db_ready_timeout", db_ready, 1);
  endtask

  task automatic load_query(input logic [1:0] b[$]);
    for (int i = 0; i < b.size(); i++) begin
      q_valid = 1'b1;
      q_base  = b[i];
      q_last  = (i == b.size() - 1);
      wait_q_ready();
      tick();
    end
    q_valid = 1'b0;
    q_last  = 1'b0;
  endtask

  task automatic send_seq(input int len);
    for (int i = 0; i < len; i++) begin
      db_valid = 1'b1;
      db_base  = 2'($urandom_range(0, 3));
      db_last  = (i == len - 1);
      wait_db_ready();
      tick();
      chk("seq_sa_en", sa_en, 1);
      chk("seq_sa_data", sa_data, db_base);
      if (i == 0) begin
        tags.push_back(nxt_id);
        nxt_id = (nxt_id + 1) % 256;
      end
    end
    db_valid = 1'b0;
    db_last  = 1'b0;
  endtask

  task automatic pulse_vld(input logic [SW-1:0] result, input logic [SW-1:0] exp_score);
    int exp_id;
    exp_id = 0;
    if (tags.size() > 0) exp_id = tags.pop_front();
    sa_vld    = 1'b1;
    sa_result = result;
    tick();
    sa_vld = 1'b0;
    chk("res_valid", res_valid, 1);
    chk("res_id", res_id, exp_id);
    chk("res_score", res_score, exp_score);
    tick();
    chk("res_valid_one_cycle", res_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  bq[$];
    logic [95:0] exp_q;
    string       s;

    tbl[0] = '{12'h811, 12'h011};
    tbl[1] = '{12'h000, 12'h800};
    tbl[2] = '{12'h7FF, 12'hFFF};
    tbl[3] = '{12'hFFF, 12'h7FF};
    tbl[4] = '{12'h800, 12'h000};
    tbl[5] = '{12'h3A5, 12'hBA5};

    // Reset state
    tick();
    tick();
    chk_zero("rst");
    rst = 1'b1;
    tick();
    chk("idle_q_ready", q_ready, 1);

    // Query ACGT
    s = "ACGT";
    bq.delete();
    for (int i = 0; i < 4; i++) bq.push_back(ConvertToBase(s[i]));
    load_query(bq);
    chk("acgt_query", sa_query[7:0], 8'b10_01_11_00);
    chk("acgt_upper_zero", sa_query[95:8], 0);
    chk("acgt_qlen", sa_qlen, 3);
    chk("acgt_q_ready_low", q_ready, 0);
    chk("acgt_no_ovf", q_ovf, 0);

    // 50-base query overflows a 48-PE array
    bq.delete();
    exp_q = '0;
    for (int i = 0; i < 50; i++) begin
      bq.push_back(2'($urandom_range(0, 3)));
      if (i < LEN) exp_q[2*i +: 2] = bq[i];
    end
    load_query(bq);
    chk("ovf_query", sa_query, exp_q);
    chk("ovf_qlen", sa_qlen, 47);
    chk("ovf_flag", q_ovf, 1);

    // Two back-to-back 3-base sequences with db_valid held high
    begin : b2b
      logic [1:0] bb[6];
      int         tr[$];
      int         pat[7];
      int         idx;
      int         cyc;
      pat = '{1, 1, 1, 0, 1, 1, 1};
      for (int i = 0; i < 6; i++) bb[i] = 2'($urandom_range(0, 3));
      idx = 0;
      cyc = 0;
      while (idx < 6 && cyc < 20) begin
        logic acc;
        db_valid = 1'b1;
        db_base  = bb[idx];
        db_last  = (idx == 2 || idx == 5);
        acc      = db_ready;
        tick();
        cyc++;
        tr.push_back(int'(sa_en));
        if (acc) begin
          chk("b2b_sa_data", sa_data, bb[idx]);
          if (idx == 0 || idx == 3) begin
            tags.push_back(nxt_id);
            nxt_id = (nxt_id + 1) % 256;
          end
          idx++;
        end
      end
      db_valid = 1'b0;
      db_last  = 1'b0;
      chk("b2b_trace_len", tr.size(), 7);
      for (int i = 0; i < 7 && i < tr.size(); i++) chk("b2b_sa_en", tr[i], pat[i]);
    end
    pulse_vld(12'h811, 12'd17);
    pulse_vld(12'h800, 12'd0);

    // Table of bias-removal vectors, one short sequence each
    for (int i = 0; i < 6; i++) begin
      send_seq(i % 3 + 1);
      pulse_vld(tbl[i].result, tbl[i].score);
    end

    // Tag FIFO full: fifth sequence held until one result returns
    for (int i = 0; i < MO; i++) send_seq(1);
    db_valid = 1'b1;
    db_base  = 2'd2;
    db_last  = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("full_db_ready", db_ready, 0);
      tick();
      chk("full_sa_en", sa_en, 0);
    end
    begin : release_one
      int exp_id;
      exp_id    = tags.pop_front();
      sa_vld    = 1'b1;
      sa_result = 12'h800;
      chk("full_pre_pop_db_ready", db_ready, 0);
      tick();
      sa_vld = 1'b0;
      chk("rel_res_valid", res_valid, 1);
      chk("rel_res_id", res_id, exp_id);
      chk("rel_db_ready", db_ready, 1);
      tick();
      chk("rel_sa_en", sa_en, 1);
      chk("rel_sa_data", sa_data, 2);
      tags.push_back(nxt_id);
      nxt_id   = (nxt_id + 1) % 256;
      db_valid = 1'b0;
      db_last  = 1'b0;
    end
    for (int i = 0; i < MO; i++) pulse_vld(12'h800, 12'd0);

    // Randomised traffic against a transaction-level model
    begin : rnd
      bit            in_seq, gap, prev_vld, exp_rv, exp_en;
      logic [1:0]    exp_data;
      int            exp_id;
      logic [SW-1:0] exp_sc;
      in_seq = 0; gap = 0; prev_vld = 0; exp_rv = 0; exp_en = 0;
      exp_data = '0; exp_id = 0; exp_sc = '0;
      for (int c = 0; c < 3000; c++) begin
        bit rdy, acc, rise;
        chk("rnd_res_valid", res_valid, exp_rv);
        if (exp_rv) begin
          chk("rnd_res_id", res_id, exp_id);
          chk("rnd_res_score", res_score, exp_sc);
        end
        chk("rnd_sa_en", sa_en, exp_en);
        if (exp_en) chk("rnd_sa_data", sa_data, exp_data);
        rdy = !gap && (in_seq || tags.size() < MO);
        chk("rnd_db_ready", db_ready, rdy);

        db_valid  = ($urandom_range(0, 3) != 0);
        db_base   = 2'($urandom_range(0, 3));
        db_last   = ($urandom_range(0, 3) == 0);
        sa_vld    = prev_vld ? ($urandom_range(0, 1) == 1)
                             : (tags.size() > 0 && $urandom_range(0, 3) == 0);
        sa_result = SW'($urandom_range(0, 4095));

        rise   = sa_vld && !prev_vld;
        acc    = db_valid && rdy;
        exp_rv = rise;
        if (rise) begin
          exp_id = tags.pop_front();
          exp_sc = SW'(int'(sa_result) + 2048);
        end
        if (acc && !in_seq) begin
          tags.push_back(nxt_id);
          nxt_id = (nxt_id + 1) % 256;
        end
        exp_en   = acc;
        exp_data = db_base;
        if (acc) begin
          in_seq = !db_last;
          gap    = db_last;
        end else begin
          gap = 0;
        end
        prev_vld = sa_vld;
        tick();
      end
      db_valid = 1'b0;
      db_last  = 1'b0;
      sa_vld   = 1'b0;
    end

    // Reset in the middle of streaming ID 2
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tags.delete();
    nxt_id = 0;
    tick();
    bq.delete();
    bq.push_back(BASE_G);
    load_query(bq);
    send_seq(1);
    send_seq(1);
    db_valid = 1'b1;
    db_base  = 2'd1;
    db_last  = 1'b0;
    wait_db_ready();
    tick();
    tick();
    chk("mid_stream_db_ready", db_ready, 1);
    db_valid = 1'b0;
    rst      = 1'b0;
    tick();
    chk_zero("abort");
    rst = 1'b1;
    tags.delete();
    nxt_id = 0;
    tick();
    bq.delete();
    bq.push_back(BASE_T);
    load_query(bq);
    send_seq(2);
    chk("post_rst_no_orphan", err_orphan, 0);
    pulse_vld(12'h805, 12'h005);
    sa_vld    = 1'b1;
    sa_result = 12'h123;
    tick();
    sa_vld = 1'b0;
    chk("orphan_res_valid", res_valid, 1);
    chk("orphan_res_id", res_id, 0);
    chk("orphan_flag", err_orphan, 1);
    tick();
    chk("orphan_sticky", err_orphan, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
